m_alu_issue: RTL
================

M_ALU_ISSUE -- requirements
Module: m_alu_issue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 w_clk  input  1  clock; all state updates on posedge w_clk.
REQ-003 w_rst  input  1  synchronous active-high reset.
REQ-004 w_ivalid  input  1  instruction word present on w_inst.
REQ-005 w_inst  input  32  R-type instruction: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0].
REQ-006 w_iready  output  1  block accepts w_inst this cycle.
REQ-007 w_ostall  input  1  downstream stall; issue register holds while high.
REQ-008 w_ovalid  output  1  w_ctl/w_a/w_b hold a valid issued operation.
REQ-009 w_ctl  output  4  ALU control code.
REQ-010 w_a, w_b  output  32 each  ALU operands (rs value, rt value).
REQ-011 w_res  input  32  combinational ALU result for the currently issued operation.
REQ-012 w_illegal  output  1  sticky flag: an illegal instruction was accepted.
REQ-013 w_retired  output  32  count of completed writebacks.
REQ-014 w_dbg_addr  input  5  debug register index; w_dbg_data  output  32  combinational read of that register.

Function
REQ-015 Decode SHALL map op=0 with funct 0x24->ctl 0 (AND), 0x25->1 (OR), 0x20->2 (ADD), 0x22->6 (SUB), 0x2A->7 (SLT), 0x27->12 (NOR).
REQ-016 Any other op/funct SHALL be illegal: sets w_illegal, issues ctl 0 with a write-enable of 0 (no writeback, no retire count).
REQ-017 w_iready SHALL equal !w_ostall || !w_ovalid.
REQ-018 On accept (w_ivalid && w_iready) the issue register SHALL load ctl, rs value, rt value, rd, write-enable and set w_ovalid=1 the next cycle (latency 1).
REQ-019 With w_iready=1 and w_ivalid=0, w_ovalid SHALL clear next cycle.
REQ-020 While w_ovalid && w_ostall, all issue-register contents SHALL hold unchanged.
REQ-021 Writeback: when w_ovalid && !w_ostall && write-enable && rd!=0, register rd SHALL be written with w_res at that clock edge and w_retired SHALL increment by 1 (wraps 2^32-1 -> 0).
REQ-022 Writeback with rd==0 SHALL be discarded yet SHALL still count as retired; register 0 SHALL always read 0.
REQ-023 Bypass: when an operand read in the accept cycle targets the register being written back in that same cycle, the operand SHALL take w_res, not the stale regfile value.
REQ-024 Bypass SHALL not apply for index 0 (always 0).
REQ-025 w_dbg_data SHALL read the register file pre-write (no bypass).
REQ-026 Back-to-back accepts every cycle SHALL be sustained when w_ostall=0 (throughput 1/cycle).

Reset
REQ-027 On w_rst=1 at a clock edge: w_ovalid=0, w_ctl=0, w_a=0, w_b=0, w_illegal=0, w_retired=0, all 32 registers=0.
REQ-028 Reset SHALL take priority over accept and writeback in the same cycle; an in-flight operation SHALL be dropped without writeback.
REQ-029 w_iready SHALL be 1 in the cycle after reset.

Structure
REQ-030 A shared package SHALL hold the ALU control constants (AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12) and funct encodings, used by this block and the ALU.
REQ-031 Register file SHALL be one sub-module m_regfile (32x32, two async read ports, one sync write port, sync reset).
REQ-032 Decode SHALL be combinational within m_alu_issue.

Verification
REQ-033 Reset, then ADD r3,r1,r2 with r1=r2=0 -> next cycle w_ovalid=1, w_ctl=2, w_a=0, w_b=0; w_retired=1 after writeback.
REQ-034 Preload r1=5 and r2=7 via writebacks, then SUB r4,r1,r2 with ALU model -> r4=0xFFFFFFFE on w_dbg_data; SLT r5,r1,r2 -> r5=1.
REQ-035 Back-to-back ADD r6,r1,r2 then OR r7,r6,r1 -> second op w_a=12 via bypass; r7=13.
REQ-036 Hold w_ostall=1 for 3 cycles with w_ovalid=1 -> w_iready=0, outputs stable, w_retired unchanged; release -> one writeback.
REQ-037 funct=0x3F -> w_illegal=1 sticky, no register change, w_retired unchanged; ADD with rd=0 -> r0 stays 0, w_retired +1.
REQ-038 Assert w_rst while w_ovalid=1 -> no writeback, all outputs at reset values next cycle.

Source files
------------

// File: rtl/m_alu_issue_pkg.sv
// Shared ALU definitions: control codes, R-type funct encodings and the decoder.
package m_alu_issue_pkg;

  localparam logic [3:0] CTL_AND = 4'd0;
  localparam logic [3:0] CTL_OR  = 4'd1;
  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_SUB = 4'd6;
  localparam logic [3:0] CTL_SLT = 4'd7;
  localparam logic [3:0] CTL_NOR = 4'd12;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  typedef struct packed {
    logic       legal;
    logic [3:0] ctl;
  } decode_t;

  // Anything that is not one of the six supported R-type ops decodes as an
  // illegal AND so the issued control code is still well defined.
  function automatic decode_t decode_inst(input logic [5:0] op, input logic [5:0] funct);
    decode_t d;
    d.legal = 1'b0;
    d.ctl   = CTL_AND;
    if (op == OP_RTYPE) begin
      d.legal = 1'b1;
      case (funct)
        FUNCT_AND: d.ctl = CTL_AND;
        FUNCT_OR:  d.ctl = CTL_OR;
        FUNCT_ADD: d.ctl = CTL_ADD;
        FUNCT_SUB: d.ctl = CTL_SUB;
        FUNCT_SLT: d.ctl = CTL_SLT;
        FUNCT_NOR: d.ctl = CTL_NOR;
        default: begin
          d.legal = 1'b0;
          d.ctl   = CTL_AND;
        end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/m_regfile.sv
// 32x32 register file: operand read ports, a debug read port, one write port.
// Register 0 is hardwired to zero on every read port.
module m_regfile (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [31:0] dbg_data,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] mem [32];

  // Synchronous clear of every register; writes to index 0 are dropped.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wen && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous reads of the stored (pre-write) contents.
  always_comb begin
    rdata_a  = (raddr_a  == 5'd0) ? 32'd0 : mem[raddr_a];
    rdata_b  = (raddr_b  == 5'd0) ? 32'd0 : mem[raddr_b];
    dbg_data = (dbg_addr == 5'd0) ? 32'd0 : mem[dbg_addr];
  end

endmodule

// File: rtl/m_alu_issue.sv
// Single-entry ALU issue stage: decode, operand read with writeback bypass,
// stallable issue register, and writeback/retire bookkeeping.
module m_alu_issue
  import m_alu_issue_pkg::*;
(
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_ivalid,
  input  logic [31:0] w_inst,
  output logic        w_iready,
  input  logic        w_ostall,
  output logic        w_ovalid,
  output logic [3:0]  w_ctl,
  output logic [31:0] w_a,
  output logic [31:0] w_b,
  input  logic [31:0] w_res,
  output logic        w_illegal,
  output logic [31:0] w_retired,
  input  logic [4:0]  w_dbg_addr,
  output logic [31:0] w_dbg_data
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  decode_t     dec;
  logic [31:0] rf_a;
  logic [31:0] rf_b;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  q_rd;
  logic        q_we;
  logic        accept;
  logic        retire_fire;
  logic        wb_en;
  logic        unused_shamt;

  assign unused_shamt = ^w_inst[10:6];

  assign w_iready    = !w_ostall || !w_ovalid;
  assign accept      = w_ivalid && w_iready;
  assign retire_fire = w_ovalid && !w_ostall && q_we;
  assign wb_en       = retire_fire && (q_rd != 5'd0);

  // Field extraction and combinational decode of the incoming instruction.
  always_comb begin
    op     = w_inst[31:26];
    rs_idx = w_inst[25:21];
    rt_idx = w_inst[20:16];
    rd_idx = w_inst[15:11];
    funct  = w_inst[5:0];
    dec    = decode_inst(op, funct);
  end

  m_regfile u_regfile (
    .w_clk    (w_clk),
    .w_rst    (w_rst),
    .raddr_a  (rs_idx),
    .raddr_b  (rt_idx),
    .dbg_addr (w_dbg_addr),
    .rdata_a  (rf_a),
    .rdata_b  (rf_b),
    .dbg_data (w_dbg_data),
    .wen      (wb_en),
    .waddr    (q_rd),
    .wdata    (w_res)
  );

  // Forward the result being written this cycle; wb_en already excludes r0.
  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    if (wb_en && (q_rd == rs_idx)) op_a = w_res;
    if (wb_en && (q_rd == rt_idx)) op_b = w_res;
  end

  // Issue register: loads on accept, empties when idle, frozen while stalled.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_ovalid <= 1'b0;
      w_ctl    <= CTL_AND;
      w_a      <= '0;
      w_b      <= '0;
      q_rd     <= '0;
      q_we     <= 1'b0;
    end else if (w_iready) begin
      w_ovalid <= w_ivalid;
      if (accept) begin
        w_ctl <= dec.ctl;
        w_a   <= op_a;
        w_b   <= op_b;
        q_rd  <= rd_idx;
        q_we  <= dec.legal;
      end
    end
  end

  // Sticky illegal flag and wrapping retire counter.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_illegal <= 1'b0;
      w_retired <= '0;
    end else begin
      if (accept && !dec.legal) w_illegal <= 1'b1;
      if (retire_fire) w_retired <= w_retired + 32'd1;
    end
  end

endmodule
